ysyx_23060124_mem_responder: RTL and testbench

Memory-side responder for the core's load/store path: an AXI4-Lite-style slave with independent read and write channels, backed by an internal word-addressed array with byte-lane write strobes. It sits where the LSU's memory requests terminate and returns load data and store acknowledgements after a controlled latency. This lets the core's memory handshakes be exercised without a DPI memory model. Accesses outside the mapped window return an error response.

---
 rtl/ysyx_23060124_mem_responder_if.sv | 35 +++
 rtl/ysyx_23060124_mem_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_ysyx_23060124_mem_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060124_mem_responder_if.sv
// AXI4-Lite-style read/write channel bundle between the LSU
// and the memory responder.
interface ysyx_23060124_mem_responder_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_23060124_mem_responder.sv
// Word-array memory responder with fixed latency, or LFSR-driven
// latency when YSYX_23060124_MEM_RAND_DELAY_EN is defined.
module ysyx_23060124_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LATENCY  = 2,
  parameter int          WR_LATENCY  = 2
) (
  input  logic clock,
  input  logic rst_n,
  ysyx_23060124_mem_responder_if.slave bus
);

  localparam int          IW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    R_IDLE, R_WAIT, R_RESP
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE, W_WAIT, W_RESP
  } w_state_t;

  function automatic logic hit(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return (a >= ADDR_BASE) && (off < SPAN);
  endfunction

  function automatic logic [IW-1:0] widx(input logic [31:0] a);
    return IW'((a - ADDR_BASE) >> 2);
  endfunction

  logic [31:0] mem [DEPTH_WORDS];
  logic [7:0]  rd_lat;
  logic [7:0]  wr_lat;

`ifdef YSYX_23060124_MEM_RAND_DELAY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign rd_lat = 8'd1 + {5'd0, lfsr[2:0]};
  assign wr_lat = 8'd1 + {5'd0, lfsr[5:3]};
`else
  assign rd_lat = 8'(RD_LATENCY);
  assign wr_lat = 8'(WR_LATENCY);
`endif

  // Read channel
  r_state_t    r_state, r_next;
  logic [7:0]  r_cnt, r_cnt_d;
  logic [31:0] r_addr, r_addr_d, r_src;
  logic        r_cap;
  logic        arready_q;
  logic        ar_hs;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  assign ar_hs = bus.arvalid && arready_q;

  // A one-cycle latency captures on the handshake edge itself.
  always_comb begin
    r_next  = r_state;
    r_cnt_d = r_cnt;
    r_addr_d = r_addr;
    r_src   = r_addr;
    r_cap   = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_addr_d = bus.araddr;
          r_src    = bus.araddr;
          if (rd_lat <= 8'd1) begin
            r_cap  = 1'b1;
            r_next = R_RESP;
          end else begin
            r_cnt_d = rd_lat - 8'd2;
            r_next  = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt == 8'd0) begin
          r_cap  = 1'b1;
          r_next = R_RESP;
        end else begin
          r_cnt_d = r_cnt - 8'd1;
        end
      end
      R_RESP: begin
        if (bus.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      r_cnt     <= 8'd0;
      r_addr    <= 32'd0;
      arready_q <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
    end else begin
      r_state   <= r_next;
      r_cnt     <= r_cnt_d;
      r_addr    <= r_addr_d;
      arready_q <= (r_next == R_IDLE);
      if (r_cap) begin
        if (hit(r_src)) begin
          rdata_q <= mem[widx(r_src)];
          rresp_q <= 2'b00;
        end else begin
          rdata_q <= 32'd0;
          rresp_q <= 2'b10;
        end
      end
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = (r_state == R_RESP);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

  // Write channel
  w_state_t    w_state, w_next;
  logic [7:0]  w_cnt, w_cnt_d;
  logic        aw_held, aw_held_d;
  logic        wd_held, wd_held_d;
  logic [31:0] w_addr, w_addr_d;
  logic [31:0] w_data, w_data_d;
  logic [3:0]  w_strb, w_strb_d;
  logic        awready_q, wready_q;
  logic        aw_hs, w_hs;
  logic        commit;
  logic [31:0] c_addr, c_data;
  logic [3:0]  c_strb;
  logic [1:0]  bresp_q;

  assign aw_hs = bus.awvalid && awready_q;
  assign w_hs  = bus.wvalid && wready_q;

  always_comb begin
    w_next    = w_state;
    w_cnt_d   = w_cnt;
    aw_held_d = aw_held;
    wd_held_d = wd_held;
    w_addr_d  = w_addr;
    w_data_d  = w_data;
    w_strb_d  = w_strb;
    commit    = 1'b0;
    c_addr    = w_addr;
    c_data    = w_data;
    c_strb    = w_strb;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          w_addr_d  = bus.awaddr;
          aw_held_d = 1'b1;
        end
        if (w_hs) begin
          w_data_d  = bus.wdata;
          w_strb_d  = bus.wstrb;
          wd_held_d = 1'b1;
        end
        c_addr = w_addr_d;
        c_data = w_data_d;
        c_strb = w_strb_d;
        if (aw_held_d && wd_held_d) begin
          aw_held_d = 1'b0;
          wd_held_d = 1'b0;
          if (wr_lat <= 8'd1) begin
            commit = 1'b1;
            w_next = W_RESP;
          end else begin
            w_cnt_d = wr_lat - 8'd2;
            w_next  = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (w_cnt == 8'd0) begin
          commit = 1'b1;
          w_next = W_RESP;
        end else begin
          w_cnt_d = w_cnt - 8'd1;
        end
      end
      W_RESP: begin
        if (bus.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      w_cnt     <= 8'd0;
      aw_held   <= 1'b0;
      wd_held   <= 1'b0;
      w_addr    <= 32'd0;
      w_data    <= 32'd0;
      w_strb    <= 4'd0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state   <= w_next;
      w_cnt     <= w_cnt_d;
      aw_held   <= aw_held_d;
      wd_held   <= wd_held_d;
      w_addr    <= w_addr_d;
      w_data    <= w_data_d;
      w_strb    <= w_strb_d;
      awready_q <= (w_next == W_IDLE) && !aw_held_d;
      wready_q  <= (w_next == W_IDLE) && !wd_held_d;
      if (commit) bresp_q <= hit(c_addr) ? 2'b00 : 2'b10;
    end
  end

  // Reset suppresses a commit due on the same edge.
  always_ff @(posedge clock) begin
    if (rst_n && commit && hit(c_addr)) begin
      for (int i = 0; i < 4; i++) begin
        if (c_strb[i]) mem[widx(c_addr)][8*i +: 8] <= c_data[8*i +: 8];
      end
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = (w_state == W_RESP);
  assign bus.bresp   = bresp_q;

endmodule

// File: tb/tb_ysyx_23060124_mem_responder.sv
// Directed plus randomized bench for the memory responder,
// checked against an associative-array memory model.
module tb_ysyx_23060124_mem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 1024;
  localparam int RLAT = 2;
  localparam int WLAT = 2;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [int];

  always #5 clock = ~clock;

  ysyx_23060124_mem_responder_if bus ();

  ysyx_23060124_mem_responder #(
    .ADDR_BASE(BASE),
    .DEPTH_WORDS(DEPTH),
    .RD_LATENCY(RLAT),
    .WR_LATENCY(WLAT)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_lat(input string tag, input int lat, input int fixed);
`ifdef YSYX_23060124_MEM_RAND_DELAY_EN
    chk(tag, 32'(lat >= 1 && lat <= 8), 32'd1);
`else
    chk(tag, 32'(lat), 32'(fixed));
`endif
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return a >= BASE && (a - BASE) < 32'(4 * DEPTH);
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic do_read(input logic [31:0] a, input int hold,
                         output logic [31:0] d, output logic [1:0] resp,
                         output int lat);
    int n;
    bus.araddr = a;
    bus.arvalid = 1'b1;
    bus.rready = (hold == 0);
    n = 0;
    while (!bus.arready && n < 20) begin step(); n++; end
    chk("ar_timeout", 32'(n < 20), 32'd1);
    step();
    bus.arvalid = 1'b0;
    lat = 1;
    while (!bus.rvalid && lat < 20) begin step(); lat++; end
    d = bus.rdata;
    resp = bus.rresp;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("r_hold_valid", 32'(bus.rvalid), 32'd1);
      chk("r_hold_data", bus.rdata, d);
    end
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
    chk("r_done", 32'(bus.rvalid), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int w_gap,
                          input int aw_gap, output logic [1:0] resp,
                          output int lat);
    bit aw_done, w_done, hs_aw, hs_w;
    int cyc;
    aw_done = 0;
    w_done = 0;
    cyc = 0;
    bus.bready = 1'b1;
    while (!(aw_done && w_done) && cyc < 30) begin
      if (!w_done && cyc >= w_gap) begin
        bus.wvalid = 1'b1;
        bus.wdata = d;
        bus.wstrb = s;
      end
      if (!aw_done && cyc >= aw_gap) begin
        bus.awvalid = 1'b1;
        bus.awaddr = a;
      end
      hs_w = bus.wvalid && bus.wready;
      hs_aw = bus.awvalid && bus.awready;
      step();
      if (hs_w) begin w_done = 1; bus.wvalid = 1'b0; end
      if (hs_aw) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (hs_w && !aw_done)
        chk("wready_drop", 32'(bus.wready), 32'd0);
      if (hs_aw && !w_done)
        chk("awready_drop", 32'(bus.awready), 32'd0);
      cyc++;
    end
    chk("aw_w_timeout", 32'(aw_done && w_done), 32'd1);
    lat = 1;
    while (!bus.bvalid && lat < 20) begin step(); lat++; end
    resp = bus.bresp;
    step();
    bus.bready = 1'b0;
    chk("b_done", 32'(bus.bvalid), 32'd0);
  endtask

  // Write through the DUT and mirror the effect into the model.
  task automatic mwrite(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int wg, input int ag);
    logic [1:0] resp;
    int lat;
    do_write(a, d, s, wg, ag, resp, lat);
    chk_lat("wr_lat", lat, WLAT);
    chk("bresp", 32'(resp), in_rng(a) ? 32'd0 : 32'd2);
    if (in_rng(a)) begin
      if (ref_mem.exists(idx(a)))
        ref_mem[idx(a)] = merge(ref_mem[idx(a)], d, s);
      else
        ref_mem[idx(a)] = merge(32'd0, d, s);
    end
  endtask

  task automatic mread(input logic [31:0] a, input int hold);
    logic [31:0] d;
    logic [1:0] resp;
    int lat;
    do_read(a, hold, d, resp, lat);
    chk_lat("rd_lat", lat, RLAT);
    chk("rresp", 32'(resp), in_rng(a) ? 32'd0 : 32'd2);
    if (!in_rng(a)) chk("rdata_oor", d, 32'd0);
    else if (ref_mem.exists(idx(a))) chk("rdata", d, ref_mem[idx(a)]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] oor [4];
    logic [31:0] a;
    bus.araddr = 0; bus.arvalid = 0; bus.rready = 0;
    bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0;
    bus.wstrb = 0; bus.wvalid = 0; bus.bready = 0;

    repeat (3) step();
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_rresp", 32'(bus.rresp), 32'd0);
    chk("rst_bresp", 32'(bus.bresp), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_arready", 32'(bus.arready), 32'd1);
    chk("rel_awready", 32'(bus.awready), 32'd1);

    mwrite(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    mread(BASE + 32'h10, 0);

    mwrite(BASE + 32'h20, 32'h11223344, 4'hF, 0, 0);
    mwrite(BASE + 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0);
    chk("strb_model", ref_mem[8], 32'h11BB33DD);
    mread(BASE + 32'h20, 0);

    mwrite(BASE + 32'h30, 32'hCAFE0001, 4'hF, 0, 3);
    mread(BASE + 32'h30, 0);
    mwrite(BASE + 32'h34, 32'h0BADF00D, 4'hF, 2, 0);
    mread(BASE + 32'h34, 1);

    mwrite(BASE, 32'h5A5A5A5A, 4'hF, 0, 0);
    mread(32'h7FFF_FFFC, 0);
    mwrite(BASE + 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 0);
    mread(BASE, 0);

    mread(BASE + 32'h10, 5);

    bus.araddr = BASE + 32'h10;
    bus.arvalid = 1'b1;
    step();
    bus.arvalid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("mid_rst_arready", 32'(bus.arready), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_arready", 32'(bus.arready), 32'd1);
    chk("post_rst_rvalid", 32'(bus.rvalid), 32'd0);

    for (int w = 0; w < 16; w++)
      mwrite(BASE + 32'(4 * w), $urandom, 4'hF, 0, 0);

    oor[0] = BASE - 32'd4;
    oor[1] = BASE + 32'h1000;
    oor[2] = 32'h0000_0000;
    oor[3] = 32'hFFFF_FFFC;
    for (int t = 0; t < 200; t++) begin
      int pick;
      pick = $urandom_range(0, 19);
      a = (pick < 16) ? BASE + 32'(4 * pick) : oor[pick - 16];
      if (pick < 16) a = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        mwrite(a, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), $urandom_range(0, 3));
      else
        mread(a, $urandom_range(0, 2));
    end

`ifndef YSYX_23060124_MEM_RAND_DELAY_EN
    bus.awaddr = BASE + 32'd20;
    bus.wdata = ~ref_mem[5];
    bus.wstrb = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    step();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("wr_rst_bvalid", 32'(bus.bvalid), 32'd0);
    step();
    chk("wr_rst_awready", 32'(bus.awready), 32'd1);
    mread(BASE + 32'd20, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
